// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone arbiter slice.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    ABORT   = 2'd2
  } wb_arb_state_t;

  // Width of a master index; never zero, even for a single master.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester strictly after last_i,
// wrapping Count-1 back to 0.
module rr_picker #(
  parameter int Count = 2,
  parameter int IdxW  = 1
) (
  input  logic [Count-1:0] req_i,
  input  logic [IdxW-1:0]  last_i,
  output logic [IdxW-1:0]  grant_o,
  output logic             valid_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = last_i;
    for (int i = 0; i < Count; i++) begin
      idx = (idx == IdxW'(Count - 1)) ? '0 : idx + 1'b1;
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone pipelined arbiter: Count masters onto one bus, with an
// outstanding-strobe cap and a response timeout that aborts the cycle.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int Count          = 2,
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 4,
  parameter int Timeout        = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DataWidth-1:0]   m_data_m [Count],
  input  logic [AddrWidth-1:0]   m_addr   [Count],
  input  logic [DataWidth/8-1:0] m_sel    [Count],
  input  logic                   m_cyc    [Count],
  input  logic                   m_stb    [Count],
  input  logic                   m_we     [Count],
  output logic [DataWidth-1:0]   m_data_s [Count],
  output logic                   m_ack    [Count],
  output logic                   m_stall  [Count],
  output logic                   m_err    [Count],
  output logic [DataWidth-1:0]   s_data_m,
  output logic [AddrWidth-1:0]   s_addr,
  output logic [DataWidth/8-1:0] s_sel,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  input  logic [DataWidth-1:0]   s_data_s,
  input  logic                   s_ack,
  input  logic                   s_stall,
  input  logic                   s_err
);

  localparam int IdxW = idxWidth(Count);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int TmrW = $clog2(Timeout + 1);
  localparam logic [CntW-1:0] CapVal = CntW'(MaxOutstanding);
  localparam logic [TmrW-1:0] TmoVal = TmrW'(Timeout);

  wb_arb_state_t   state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmrW-1:0] timer_q, timer_d;

  logic [Count-1:0] reqVec;
  logic [IdxW-1:0]  pickIdx;
  logic             pickValid;
  logic granted, gCyc, gStb, atCap, busy, resp, toHit, active, accepted;

  always_comb begin
    for (int i = 0; i < Count; i++) reqVec[i] = m_cyc[i];
  end

  rr_picker #(
    .Count(Count),
    .IdxW (IdxW)
  ) u_picker (
    .req_i  (reqVec),
    .last_i (last_q),
    .grant_o(pickIdx),
    .valid_o(pickValid)
  );

  // Reset gates the bus immediately so a mid-transaction reset never leaks a strobe or error.
  always_comb begin
    granted  = (state_q == GRANTED) && !reset;
    gCyc     = m_cyc[grant_q];
    gStb     = m_stb[grant_q];
    atCap    = (cnt_q == CapVal);
    busy     = (cnt_q != '0);
    resp     = granted && gCyc && busy && (s_ack || s_err);
    toHit    = granted && gCyc && busy && !(s_ack || s_err) && (timer_q == TmoVal);
    active   = granted && gCyc && !toHit;
    s_cyc    = active;
    s_stb    = active && gStb && !atCap;
    s_data_m = m_data_m[grant_q];
    s_addr   = m_addr[grant_q];
    s_sel    = m_sel[grant_q];
    s_we     = m_we[grant_q];
    accepted = s_stb && !s_stall;
  end

  always_comb begin
    for (int i = 0; i < Count; i++) begin
      m_stall[i]  = 1'b1;
      m_ack[i]    = 1'b0;
      m_err[i]    = 1'b0;
      m_data_s[i] = '0;
    end
    if (active) begin
      m_stall[grant_q]  = s_stall || atCap;
      m_data_s[grant_q] = s_data_s;
    end
    if (resp) begin
      m_ack[grant_q] = s_ack;
      m_err[grant_q] = s_err;
    end
    if (toHit) m_err[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          grant_d = pickIdx;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (!gCyc) begin
          state_d = IDLE;
          last_d  = grant_q;
          cnt_d   = '0;
          timer_d = '0;
        end else if (toHit) begin
          state_d = ABORT;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          if (accepted && !resp)      cnt_d = cnt_q + 1'b1;
          else if (resp && !accepted) cnt_d = cnt_q - 1'b1;
          if (resp || !busy)          timer_d = '0;
          else if (timer_q != TmoVal) timer_d = timer_q + 1'b1;
        end
      end
      ABORT: begin
        if (!gCyc) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IdxW'(Count - 1);
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a per-cycle vector table followed by
// hand-written sequences for the cap, reset and timeout corners.
module tb_wb_arbiter;

  // stim   = {reset, cyc0, stb0, cyc1, stb1, s_ack, s_stall, s_err}
  // expOut = {s_cyc, s_stb, stall0, stall1, ack0, ack1, err0, err1}
  typedef struct {
    logic [7:0]  stim;
    logic [7:0]  expOut;
    logic [31:0] expAddr;
  } vec_t;

  localparam logic [31:0] Addr0  = 32'h0000_0100;
  localparam logic [31:0] Addr1  = 32'h0000_0200;
  localparam logic [31:0] Data0  = 32'hA0A0_0000;
  localparam logic [31:0] Data1  = 32'hB1B1_0000;
  localparam logic [31:0] SlvDat = 32'h5A5A_1234;

  logic        clk;
  logic        reset;
  logic [31:0] mDataM [2];
  logic [31:0] mAddr  [2];
  logic [3:0]  mSel   [2];
  logic        mCyc   [2];
  logic        mStb   [2];
  logic        mWe    [2];
  logic [31:0] mDataS [2];
  logic        mAck   [2];
  logic        mStall [2];
  logic        mErr   [2];
  logic [31:0] sDataM;
  logic [31:0] sAddr;
  logic [3:0]  sSel;
  logic        sCyc, sStb, sWe;
  logic [31:0] sDataS;
  logic        sAck, sStall, sErr;

  int checks = 0;
  int errors = 0;
  vec_t vecs [14];

  wb_arbiter #(
    .Count(2), .DataWidth(32), .AddrWidth(32), .MaxOutstanding(4), .Timeout(255)
  ) dut (
    .clk(clk), .reset(reset),
    .m_data_m(mDataM), .m_addr(mAddr), .m_sel(mSel),
    .m_cyc(mCyc), .m_stb(mStb), .m_we(mWe),
    .m_data_s(mDataS), .m_ack(mAck), .m_stall(mStall), .m_err(mErr),
    .s_data_m(sDataM), .s_addr(sAddr), .s_sel(sSel),
    .s_cyc(sCyc), .s_stb(sStb), .s_we(sWe),
    .s_data_s(sDataS), .s_ack(sAck), .s_stall(sStall), .s_err(sErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] stim);
    {reset, mCyc[0], mStb[0], mCyc[1], mStb[1], sAck, sStall, sErr} = stim;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlags(input string tag, input logic [7:0] e, input logic [31:0] addr);
    checkBit({tag, " s_cyc"},  sCyc,      e[7]);
    checkBit({tag, " s_stb"},  sStb,      e[6]);
    checkBit({tag, " stall0"}, mStall[0], e[5]);
    checkBit({tag, " stall1"}, mStall[1], e[4]);
    checkBit({tag, " ack0"},   mAck[0],   e[3]);
    checkBit({tag, " ack1"},   mAck[1],   e[2]);
    checkBit({tag, " err0"},   mErr[0],   e[1]);
    checkBit({tag, " err1"},   mErr[1],   e[0]);
    if (e[7]) begin
      checkOutput({tag, " s_addr"}, sAddr, addr);
      checkOutput({tag, " s_data_m"}, sDataM, (addr == Addr0) ? Data0 : Data1);
      checkBit({tag, " s_we"}, sWe, (addr == Addr0));
    end
  endtask

  // Keeps strobing until the outstanding cap closes: four accepts, then stalled.
  task automatic fillToCap(input string tag, input logic [7:0] stim);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(stim);
      #1;
      checkBit($sformatf("%s fill%0d s_stb", tag, k), sStb, 1'b1);
      checkBit($sformatf("%s fill%0d stall0", tag, k), mStall[0], 1'b0);
      nextCycle();
    end
    applyStimulus(stim);
    #1;
    checkBit({tag, " cap s_stb"}, sStb, 1'b0);
    checkBit({tag, " cap stall0"}, mStall[0], 1'b1);
    checkBit({tag, " cap s_cyc"}, sCyc, 1'b1);
    nextCycle();
  endtask

  initial begin
    mDataM[0] = Data0;  mDataM[1] = Data1;
    mAddr[0]  = Addr0;  mAddr[1]  = Addr1;
    mSel[0]   = 4'hF;   mSel[1]   = 4'hF;
    mWe[0]    = 1'b1;   mWe[1]    = 1'b0;
    sDataS    = SlvDat;
    applyStimulus(8'b1000_0000);

    vecs[0]  = '{8'b1000_0000, 8'b0011_0000, 32'h0};
    vecs[1]  = '{8'b0110_0000, 8'b0011_0000, 32'h0};
    vecs[2]  = '{8'b0110_0000, 8'b1101_0000, Addr0};
    vecs[3]  = '{8'b0100_0100, 8'b1001_1000, Addr0};
    vecs[4]  = '{8'b0001_1000, 8'b0011_0000, 32'h0};
    vecs[5]  = '{8'b0111_1000, 8'b0011_0000, 32'h0};
    vecs[6]  = '{8'b0111_1000, 8'b1110_0000, Addr1};
    vecs[7]  = '{8'b0111_0100, 8'b1010_0100, Addr1};
    vecs[8]  = '{8'b0110_0000, 8'b0011_0000, 32'h0};
    vecs[9]  = '{8'b0111_1000, 8'b0011_0000, 32'h0};
    vecs[10] = '{8'b0111_1000, 8'b1101_0000, Addr0};
    vecs[11] = '{8'b0111_1110, 8'b1111_1000, Addr0};
    vecs[12] = '{8'b0101_1100, 8'b1001_0000, Addr0};
    vecs[13] = '{8'b0101_1001, 8'b1001_0000, Addr0};

    nextCycle();

    // Grant latency, alternation 0,1,0, stalled ack, ignored responses at zero count.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].stim);
      #1;
      checkFlags($sformatf("row%0d", i), vecs[i].expOut, vecs[i].expAddr);
      if (i == 3) begin
        checkOutput("row3 m_data_s0", mDataS[0], SlvDat);
        checkOutput("row3 m_data_s1", mDataS[1], 32'h0);
      end
      nextCycle();
    end

    // Outstanding cap, then a simultaneous accept and ack at count 2.
    fillToCap("capA", 8'b0111_1000);
    applyStimulus(8'b0111_1100);
    #1;
    checkBit("capAck ack0", mAck[0], 1'b1);
    checkBit("capAck s_stb", sStb, 1'b0);
    nextCycle();
    applyStimulus(8'b0101_1100);
    #1;
    checkBit("ack3 ack0", mAck[0], 1'b1);
    checkBit("ack3 ack1", mAck[1], 1'b0);
    checkOutput("ack3 m_data_s0", mDataS[0], SlvDat);
    checkOutput("ack3 m_data_s1", mDataS[1], 32'h0);
    nextCycle();
    applyStimulus(8'b0111_1100);
    #1;
    checkBit("both s_stb", sStb, 1'b1);
    checkBit("both ack0", mAck[0], 1'b1);
    checkBit("both ack1", mAck[1], 1'b0);
    checkBit("both stall0", mStall[0], 1'b0);
    nextCycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(8'b0111_1000);
      #1;
      checkBit($sformatf("after2 fill%0d s_stb", k), sStb, 1'b1);
      nextCycle();
    end
    applyStimulus(8'b0111_1000);
    #1;
    checkBit("after2 cap s_stb", sStb, 1'b0);
    checkBit("after2 cap stall0", mStall[0], 1'b1);
    nextCycle();

    // Reset with three strobes outstanding.
    applyStimulus(8'b0101_1100);
    #1;
    checkBit("pre-reset ack0", mAck[0], 1'b1);
    nextCycle();
    applyStimulus(8'b1110_0000);
    #1;
    checkBit("inReset s_cyc", sCyc, 1'b0);
    checkBit("inReset s_stb", sStb, 1'b0);
    checkBit("inReset err0", mErr[0], 1'b0);
    checkBit("inReset stall0", mStall[0], 1'b1);
    nextCycle();
    applyStimulus(8'b0111_1000);
    #1;
    checkBit("postReset s_cyc", sCyc, 1'b0);
    checkBit("postReset err0", mErr[0], 1'b0);
    checkBit("postReset stall0", mStall[0], 1'b1);
    checkBit("postReset stall1", mStall[1], 1'b1);
    nextCycle();
    fillToCap("capB", 8'b0111_1000);
    applyStimulus(8'b0000_0000);
    #1;
    checkBit("drop s_cyc", sCyc, 1'b0);
    checkBit("drop stall0", mStall[0], 1'b1);
    nextCycle();

    // One strobe never answered: error pulse after Timeout idle cycles, then ABORT.
    applyStimulus(8'b0110_0000);
    #1;
    checkBit("toIdle s_cyc", sCyc, 1'b0);
    nextCycle();
    applyStimulus(8'b0110_0000);
    #1;
    checkBit("toGrant s_stb", sStb, 1'b1);
    checkOutput("toGrant s_addr", sAddr, Addr0);
    nextCycle();
    for (int c = 1; c <= 255; c++) begin
      applyStimulus(8'b0100_0000);
      #1;
      checkBit($sformatf("wait%0d err0", c), mErr[0], 1'b0);
      checkBit($sformatf("wait%0d s_cyc", c), sCyc, 1'b1);
      nextCycle();
    end
    applyStimulus(8'b0100_0000);
    #1;
    checkBit("timeout err0", mErr[0], 1'b1);
    checkBit("timeout err1", mErr[1], 1'b0);
    checkBit("timeout s_cyc", sCyc, 1'b0);
    checkBit("timeout s_stb", sStb, 1'b0);
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'b0101_1000);
      #1;
      checkBit($sformatf("abort%0d err0", k), mErr[0], 1'b0);
      checkBit($sformatf("abort%0d s_cyc", k), sCyc, 1'b0);
      checkBit($sformatf("abort%0d stall1", k), mStall[1], 1'b1);
      nextCycle();
    end
    applyStimulus(8'b0001_1000);
    #1;
    checkBit("abortExit s_cyc", sCyc, 1'b0);
    nextCycle();
    applyStimulus(8'b0001_1000);
    #1;
    checkBit("reIdle s_cyc", sCyc, 1'b0);
    nextCycle();
    applyStimulus(8'b0001_1000);
    #1;
    checkBit("regrant1 s_cyc", sCyc, 1'b1);
    checkOutput("regrant1 s_addr", sAddr, Addr1);
    checkOutput("regrant1 s_data_m", sDataM, Data1);
    checkBit("regrant1 s_we", sWe, 1'b0);
    checkBit("regrant1 stall0", mStall[0], 1'b1);
    checkBit("regrant1 stall1", mStall[1], 1'b0);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
